// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: registered instruction-decode control stage.
// Decodes one MIPS instruction per valid/ready transfer into the ID control
// word. Adds a pipeline register, downstream backpressure, flush, a HI/LO
// multiply/divide interlock counter, branch-delay-slot tracking and optional
// COP0 decode.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               kill stage contents; blocks transfer this cycle
//   in_valid/in_ready   upstream handshake; in_inst/in_pc instruction and PC
//   out_valid/out_ready downstream handshake; out_inst/out_pc registered copies
//   alu_op .. bad_inst  registered control word
//   in_delay_slot       registered instruction sits in a branch delay slot
module id_ctrl_stage #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter bit          CP0_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [4:0]  alu_op,
  output logic        alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic        mem_to_reg,
  output logic [3:0]  mem_read_en,
  output logic [3:0]  mem_write,
  output logic [1:0]  jump,
  output logic        pc8,
  output logic        branch,
  output logic        cp0_write,
  output logic        eret,
  output logic [1:0]  trap,
  output logic        bad_inst,
  output logic        in_delay_slot
);

  localparam logic [3:0] LAT = 4'(MULDIV_LAT);

  typedef struct packed {
    logic [4:0] alu_op;
    logic       alu_a_sel;
    logic [1:0] alu_b_sel;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       mem_to_reg;
    logic [3:0] mem_read_en;
    logic [3:0] mem_write;
    logic [1:0] jump;
    logic       pc8;
    logic       branch;
    logic       cp0_write;
    logic       eret;
    logic [1:0] trap;
    logic       bad_inst;
  } ctrl_t;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt;
  logic       rd_nz;
  ctrl_t      dec, ctrl_q;
  logic       unknown;
  logic       is_muldiv, is_hilo, is_cti;
  logic       interlock, transfer;
  logic [3:0] muldiv_cnt;
  logic       ds_pending;

  assign opcode = in_inst[31:26];
  assign rs     = in_inst[25:21];
  assign rt     = in_inst[20:16];
  assign rd_nz  = in_inst[15:11] != 5'd0;
  assign funct  = in_inst[5:0];

  assign is_muldiv = (opcode == 6'b000000) && (funct[5:2] == 4'b0110);
  assign is_hilo   = (opcode == 6'b000000) && (funct[5:2] == 4'b0100);
  // Control-transfer instructions whose successor occupies the delay slot.
  assign is_cti    = (opcode == 6'b000001) || (opcode == 6'b000010) ||
                     (opcode == 6'b000011) || (opcode[5:2] == 4'b0001) ||
                     ((opcode == 6'b000000) && (funct[5:1] == 5'b00100));

  // Depends on the presented word, never on in_valid.
  assign interlock = (muldiv_cnt != 4'd0) && (is_muldiv || is_hilo);
  assign in_ready  = !flush && !interlock && (!out_valid || out_ready);
  assign transfer  = in_valid && in_ready;

  always_comb begin
    dec     = '0;
    unknown = 1'b0;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b000000: begin dec.alu_op = 5'b01000; dec.alu_a_sel = 1'b1; dec.reg_write = rd_nz; end
          6'b000010: begin dec.alu_op = 5'b01001; dec.alu_a_sel = 1'b1; dec.reg_write = rd_nz; end
          6'b000011: begin dec.alu_op = 5'b01010; dec.alu_a_sel = 1'b1; dec.reg_write = rd_nz; end
          6'b000100: begin dec.alu_op = 5'b01000; dec.reg_write = rd_nz; end
          6'b000110: begin dec.alu_op = 5'b01001; dec.reg_write = rd_nz; end
          6'b000111: begin dec.alu_op = 5'b01010; dec.reg_write = rd_nz; end
          6'b001000: dec.jump = 2'b10;
          6'b001001: begin dec.jump = 2'b10; dec.pc8 = 1'b1; dec.reg_write = rd_nz; end
          6'b001100: dec.trap = 2'b11;
          6'b001101: dec.trap = 2'b10;
          6'b010000: begin dec.alu_op = 5'b01100; dec.reg_write = rd_nz; end
          6'b010001: dec.alu_op = 5'b01110;
          6'b010010: begin dec.alu_op = 5'b01101; dec.reg_write = rd_nz; end
          6'b010011: dec.alu_op = 5'b01111;
          6'b011000, 6'b011001, 6'b011010, 6'b011011:
            dec.alu_op = {3'b111, funct[1:0]};
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111: begin
            dec.alu_op    = {2'b10, funct[2:0]};
            dec.reg_write = rd_nz;
          end
          6'b101010: begin dec.alu_op = 5'b11010; dec.reg_write = rd_nz; end
          6'b101011: begin dec.alu_op = 5'b11011; dec.reg_write = rd_nz; end
          default:   unknown = 1'b1;
        endcase
      end
      6'b000001: begin
        dec.branch = 1'b1;
        case (rt)
          5'b00000: dec.alu_op = 5'b00110;
          5'b00001: dec.alu_op = 5'b00011;
          5'b10000: begin dec.alu_op = 5'b00110; dec.pc8 = 1'b1; dec.reg_dst = 2'b10; dec.reg_write = 1'b1; end
          5'b10001: begin dec.alu_op = 5'b00011; dec.pc8 = 1'b1; dec.reg_dst = 2'b10; dec.reg_write = 1'b1; end
          default:  begin dec.branch = 1'b0; unknown = 1'b1; end
        endcase
      end
      6'b000010: dec.jump = 2'b11;
      6'b000011: begin dec.jump = 2'b11; dec.pc8 = 1'b1; dec.reg_dst = 2'b10; dec.reg_write = 1'b1; end
      6'b000100: begin dec.alu_op = 5'b00001; dec.branch = 1'b1; end
      6'b000101: begin dec.alu_op = 5'b00010; dec.branch = 1'b1; end
      6'b000110: begin dec.alu_op = 5'b00101; dec.branch = 1'b1; end
      6'b000111: begin dec.alu_op = 5'b00100; dec.branch = 1'b1; end
      6'b001000: begin dec.alu_op = 5'b10000; dec.alu_b_sel = 2'b01; dec.reg_dst = 2'b01; dec.reg_write = 1'b1; end
      6'b001001: begin dec.alu_op = 5'b10001; dec.alu_b_sel = 2'b01; dec.reg_dst = 2'b01; dec.reg_write = 1'b1; end
      6'b001010: begin dec.alu_op = 5'b11010; dec.alu_b_sel = 2'b01; dec.reg_dst = 2'b01; dec.reg_write = 1'b1; end
      6'b001011: begin dec.alu_op = 5'b11011; dec.alu_b_sel = 2'b01; dec.reg_dst = 2'b01; dec.reg_write = 1'b1; end
      6'b001100: begin dec.alu_op = 5'b10100; dec.alu_b_sel = 2'b10; dec.reg_dst = 2'b01; dec.reg_write = 1'b1; end
      6'b001101: begin dec.alu_op = 5'b10101; dec.alu_b_sel = 2'b10; dec.reg_dst = 2'b01; dec.reg_write = 1'b1; end
      6'b001110: begin dec.alu_op = 5'b10110; dec.alu_b_sel = 2'b10; dec.reg_dst = 2'b01; dec.reg_write = 1'b1; end
      6'b001111: begin dec.alu_op = 5'b00111; dec.alu_b_sel = 2'b10; dec.reg_dst = 2'b01; dec.reg_write = 1'b1; end
      6'b010000: begin
        if (!CP0_EN) begin
          unknown = 1'b1;
        end else if (rs == 5'b00000) begin
          dec.reg_dst   = 2'b01;
          dec.reg_write = 1'b1;
        end else if (rs == 5'b00100) begin
          dec.cp0_write = 1'b1;
        end else if ((rs == 5'b10000) && (funct == 6'b011000)) begin
          dec.eret = 1'b1;
        end else begin
          unknown = 1'b1;
        end
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        dec.alu_op     = 5'b10001;
        dec.alu_b_sel  = 2'b01;
        dec.reg_dst    = 2'b01;
        dec.reg_write  = 1'b1;
        dec.mem_to_reg = 1'b1;
        case (opcode[2:0])
          3'b000:  dec.mem_read_en = 4'b1001;
          3'b001:  dec.mem_read_en = 4'b1011;
          3'b011:  dec.mem_read_en = 4'b1111;
          3'b100:  dec.mem_read_en = 4'b0001;
          default: dec.mem_read_en = 4'b0011;
        endcase
      end
      6'b101000, 6'b101001, 6'b101011: begin
        dec.alu_op    = 5'b10001;
        dec.alu_b_sel = 2'b01;
        case (opcode[1:0])
          2'b00:   dec.mem_write = 4'b0001;
          2'b01:   dec.mem_write = 4'b0011;
          default: dec.mem_write = 4'b1111;
        endcase
      end
      default: unknown = 1'b1;
    endcase

    dec.bad_inst = unknown && (in_inst != 32'd0);
    // Faulting or trapping instructions must not leave architectural side effects.
    if (dec.bad_inst || (dec.trap != 2'b00)) begin
      dec.reg_write = 1'b0;
      dec.mem_write = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      ctrl_q        <= '0;
      in_delay_slot <= 1'b0;
      ds_pending    <= 1'b0;
      out_inst      <= '0;
      out_pc        <= '0;
      muldiv_cnt    <= '0;
    end else begin
      // Counter keeps running through flushes; only a new MULT/DIV reloads it.
      if (transfer && is_muldiv) begin
        muldiv_cnt <= LAT;
      end else if (muldiv_cnt != 4'd0) begin
        muldiv_cnt <= muldiv_cnt - 4'd1;
      end

      if (flush) begin
        out_valid     <= 1'b0;
        ctrl_q        <= '0;
        in_delay_slot <= 1'b0;
        ds_pending    <= 1'b0;
      end else if (transfer) begin
        out_valid     <= 1'b1;
        ctrl_q        <= dec;
        in_delay_slot <= ds_pending;
        ds_pending    <= is_cti;
        out_inst      <= in_inst;
        out_pc        <= in_pc;
      end else if (out_valid && out_ready) begin
        out_valid     <= 1'b0;
        ctrl_q        <= '0;
        in_delay_slot <= 1'b0;
      end
    end
  end

  assign alu_op      = ctrl_q.alu_op;
  assign alu_a_sel   = ctrl_q.alu_a_sel;
  assign alu_b_sel   = ctrl_q.alu_b_sel;
  assign reg_write   = ctrl_q.reg_write;
  assign reg_dst     = ctrl_q.reg_dst;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign mem_read_en = ctrl_q.mem_read_en;
  assign mem_write   = ctrl_q.mem_write;
  assign jump        = ctrl_q.jump;
  assign pc8         = ctrl_q.pc8;
  assign branch      = ctrl_q.branch;
  assign cp0_write   = ctrl_q.cp0_write;
  assign eret        = ctrl_q.eret;
  assign trap        = ctrl_q.trap;
  assign bad_inst    = ctrl_q.bad_inst;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb_id_ctrl_stage: directed self-checking bench for id_ctrl_stage.
// Main instance uses MULDIV_LAT=4, CP0_EN=1; a second instance with CP0_EN=0
// shares the same stimulus and is checked for COP0 rejection.
module tb_id_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid;
  logic [31:0] out_inst, out_pc;
  logic [4:0]  alu_op;
  logic        alu_a_sel;
  logic [1:0]  alu_b_sel;
  logic        reg_write;
  logic [1:0]  reg_dst;
  logic        mem_to_reg;
  logic [3:0]  mem_read_en, mem_write;
  logic [1:0]  jump;
  logic        pc8, branch, cp0_write, eret;
  logic [1:0]  trap;
  logic        bad_inst, in_delay_slot;

  logic        in_ready2, out_valid2;
  logic [31:0] out_inst2, out_pc2;
  logic [4:0]  alu_op2;
  logic        alu_a_sel2;
  logic [1:0]  alu_b_sel2;
  logic        reg_write2;
  logic [1:0]  reg_dst2;
  logic        mem_to_reg2;
  logic [3:0]  mem_read_en2, mem_write2;
  logic [1:0]  jump2;
  logic        pc82, branch2, cp0_write2, eret2;
  logic [1:0]  trap2;
  logic        bad_inst2, in_delay_slot2;

  logic [29:0] ctrl_bus;
  assign ctrl_bus = {alu_op, alu_a_sel, alu_b_sel, reg_write, reg_dst, mem_to_reg,
                     mem_read_en, mem_write, jump, pc8, branch, cp0_write, eret,
                     trap, bad_inst, in_delay_slot};

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDU  = 32'h0022_1821;
  localparam logic [31:0] SW    = 32'hAC22_0004;
  localparam logic [31:0] BEQ   = 32'h1022_0003;
  localparam logic [31:0] ADDIU = 32'h2403_0005;
  localparam logic [31:0] JR31  = 32'h03E0_0008;
  localparam logic [31:0] MULT  = 32'h0022_0018;
  localparam logic [31:0] MFLO  = 32'h0000_1812;
  localparam logic [31:0] ILL   = 32'hFC00_0000;
  localparam logic [31:0] MFC0  = 32'h4003_6000;
  localparam logic [31:0] SYSC  = 32'h0000_000C;

  always #5 clk = ~clk;

  id_ctrl_stage #(.MULDIV_LAT(4), .CP0_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .alu_op(alu_op), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .mem_read_en(mem_read_en), .mem_write(mem_write),
    .jump(jump), .pc8(pc8), .branch(branch), .cp0_write(cp0_write), .eret(eret),
    .trap(trap), .bad_inst(bad_inst), .in_delay_slot(in_delay_slot)
  );

  id_ctrl_stage #(.MULDIV_LAT(4), .CP0_EN(1'b0)) dut_nocp0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid2), .out_ready(out_ready),
    .out_inst(out_inst2), .out_pc(out_pc2), .alu_op(alu_op2), .alu_a_sel(alu_a_sel2),
    .alu_b_sel(alu_b_sel2), .reg_write(reg_write2), .reg_dst(reg_dst2),
    .mem_to_reg(mem_to_reg2), .mem_read_en(mem_read_en2), .mem_write(mem_write2),
    .jump(jump2), .pc8(pc82), .branch(branch2), .cp0_write(cp0_write2), .eret(eret2),
    .trap(trap2), .bad_inst(bad_inst2), .in_delay_slot(in_delay_slot2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_inst = ADDU; in_pc = 32'h0000_0100;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++;
    if (ctrl_bus !== 30'd0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", ctrl_bus); end
    checks++;
    if ({out_inst, out_pc} !== 64'd0) begin errors++; $display("FAIL reset_instpc: got %h want 0", {out_inst, out_pc}); end
    rst = 1'b0; in_valid = 1'b0;
    step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_inst = ADDU; in_pc = 32'h0000_0100;
    step();
    checks++;
    if ({out_valid, alu_op, reg_write, reg_dst, bad_inst} !== {1'b1, 5'b10001, 1'b1, 2'b00, 1'b0})
    begin errors++; $display("FAIL addu_decode: got %b want %b",
      {out_valid, alu_op, reg_write, reg_dst, bad_inst}, {1'b1, 5'b10001, 1'b1, 2'b00, 1'b0}); end
    checks++;
    if ({out_inst, out_pc} !== {ADDU, 32'h0000_0100}) begin errors++;
      $display("FAIL addu_instpc: got %h want %h", {out_inst, out_pc}, {ADDU, 32'h0000_0100}); end
    in_inst = SW; in_pc = 32'h0000_0104;
    step();
    checks++;
    if ({out_valid, mem_write, reg_write, alu_op, alu_b_sel, mem_read_en} !==
        {1'b1, 4'b1111, 1'b0, 5'b10001, 2'b01, 4'b0000}) begin errors++;
      $display("FAIL sw_decode: got %b want %b", {out_valid, mem_write, reg_write, alu_op, alu_b_sel, mem_read_en},
        {1'b1, 4'b1111, 1'b0, 5'b10001, 2'b01, 4'b0000}); end
    in_valid = 1'b0;
    step();
    checks++;
    if ({out_valid, ctrl_bus} !== 31'd0) begin errors++; $display("FAIL bubble_ctrl: got %h want 0", {out_valid, ctrl_bus}); end
    checks++;
    if (out_pc !== 32'h0000_0104) begin errors++; $display("FAIL bubble_pc_hold: got %h want 00000104", out_pc); end
  endtask

  task automatic test_delay_slot();
    in_valid = 1'b1; in_inst = BEQ; in_pc = 32'h0000_0200;
    step();
    checks++;
    if ({branch, alu_op, in_delay_slot} !== {1'b1, 5'b00001, 1'b0}) begin errors++;
      $display("FAIL beq_decode: got %b want %b", {branch, alu_op, in_delay_slot}, {1'b1, 5'b00001, 1'b0}); end
    in_inst = ADDIU; in_pc = 32'h0000_0204;
    step();
    checks++;
    if ({in_delay_slot, reg_write, reg_dst, alu_b_sel, alu_op, branch} !==
        {1'b1, 1'b1, 2'b01, 2'b01, 5'b10001, 1'b0}) begin errors++;
      $display("FAIL addiu_ds: got %b want %b", {in_delay_slot, reg_write, reg_dst, alu_b_sel, alu_op, branch},
        {1'b1, 1'b1, 2'b01, 2'b01, 5'b10001, 1'b0}); end
    in_inst = ADDU; in_pc = 32'h0000_0208;
    step();
    checks++;
    if (in_delay_slot !== 1'b0) begin errors++; $display("FAIL addu_not_ds: got %b want 0", in_delay_slot); end
    // Branch inside a delay slot: both flags propagate.
    in_inst = JR31;
    step();
    checks++;
    if ({jump, in_delay_slot} !== {2'b10, 1'b0}) begin errors++;
      $display("FAIL jr_decode: got %b want %b", {jump, in_delay_slot}, {2'b10, 1'b0}); end
    in_inst = BEQ;
    step();
    checks++;
    if ({branch, in_delay_slot} !== 2'b11) begin errors++; $display("FAIL beq_in_ds: got %b want 11", {branch, in_delay_slot}); end
    in_inst = ADDIU;
    step();
    checks++;
    if (in_delay_slot !== 1'b1) begin errors++; $display("FAIL addiu_after_nested: got %b want 1", in_delay_slot); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_interlock();
    in_valid = 1'b1; in_inst = MULT; in_pc = 32'h0000_0300;
    step();
    checks++;
    if ({out_valid, alu_op, reg_write} !== {1'b1, 5'b11100, 1'b0}) begin errors++;
      $display("FAIL mult_decode: got %b want %b", {out_valid, alu_op, reg_write}, {1'b1, 5'b11100, 1'b0}); end
    in_inst = MFLO; in_pc = 32'h0000_0304;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL interlock_ready[%0d]: got %b want 0", i, in_ready); end
      step();
    end
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin errors++;
      $display("FAIL interlock_release: got %b want 10", {in_ready, out_valid}); end
    step();
    checks++;
    if ({out_valid, alu_op, reg_write, out_pc} !== {1'b1, 5'b01101, 1'b1, 32'h0000_0304}) begin errors++;
      $display("FAIL mflo_accept: got %h want %h", {out_valid, alu_op, reg_write, out_pc},
        {1'b1, 5'b01101, 1'b1, 32'h0000_0304}); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; in_inst = ILL; in_pc = 32'h0000_0400;
    step();
    checks++;
    if ({bad_inst, reg_write, mem_write} !== {1'b1, 1'b0, 4'b0000}) begin errors++;
      $display("FAIL ill_decode: got %b want %b", {bad_inst, reg_write, mem_write}, {1'b1, 1'b0, 4'b0000}); end
    in_inst = 32'h0000_0000;
    step();
    checks++;
    if ({out_valid, bad_inst, reg_write, alu_op, alu_a_sel} !== {1'b1, 1'b0, 1'b0, 5'b01000, 1'b1}) begin errors++;
      $display("FAIL nop_decode: got %b want %b", {out_valid, bad_inst, reg_write, alu_op, alu_a_sel},
        {1'b1, 1'b0, 1'b0, 5'b01000, 1'b1}); end
    in_inst = SYSC;
    step();
    checks++;
    if ({trap, reg_write, bad_inst} !== {2'b11, 1'b0, 1'b0}) begin errors++;
      $display("FAIL syscall_decode: got %b want %b", {trap, reg_write, bad_inst}, {2'b11, 1'b0, 1'b0}); end
    in_inst = MFC0;
    step();
    checks++;
    if ({bad_inst, reg_write, reg_dst} !== {1'b0, 1'b1, 2'b01}) begin errors++;
      $display("FAIL mfc0_cp0en1: got %b want %b", {bad_inst, reg_write, reg_dst}, {1'b0, 1'b1, 2'b01}); end
    checks++;
    if ({out_valid2, bad_inst2, reg_write2} !== {1'b1, 1'b1, 1'b0}) begin errors++;
      $display("FAIL mfc0_cp0en0: got %b want %b", {out_valid2, bad_inst2, reg_write2}, {1'b1, 1'b1, 1'b0}); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_inst = ADDU; in_pc = 32'h0000_0500; out_ready = 1'b0;
    step();
    in_inst = SW; in_pc = 32'h0000_0504;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({in_ready, out_valid, alu_op, reg_write, mem_write, out_inst, out_pc} !==
          {1'b0, 1'b1, 5'b10001, 1'b1, 4'b0000, ADDU, 32'h0000_0500}) begin errors++;
        $display("FAIL stall_hold[%0d]: got %h want %h", i,
          {in_ready, out_valid, alu_op, reg_write, mem_write, out_inst, out_pc},
          {1'b0, 1'b1, 5'b10001, 1'b1, 4'b0000, ADDU, 32'h0000_0500}); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %b want 1", in_ready); end
    step();
    checks++;
    if ({mem_write, out_pc} !== {4'b1111, 32'h0000_0504}) begin errors++;
      $display("FAIL sw_after_stall: got %h want %h", {mem_write, out_pc}, {4'b1111, 32'h0000_0504}); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_flush();
    int n;
    in_valid = 1'b1; in_inst = BEQ; in_pc = 32'h0000_0600;
    step();
    in_inst = ADDIU; in_pc = 32'h0000_0604; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    step();
    checks++;
    if ({out_valid, ctrl_bus} !== 31'd0) begin errors++; $display("FAIL flush_kill: got %h want 0", {out_valid, ctrl_bus}); end
    flush = 1'b0;
    step();
    checks++;
    if ({out_valid, out_pc, in_delay_slot} !== {1'b1, 32'h0000_0604, 1'b0}) begin errors++;
      $display("FAIL flush_ds_clear: got %h want %h", {out_valid, out_pc, in_delay_slot}, {1'b1, 32'h0000_0604, 1'b0}); end
    // Counter keeps decrementing across a flush.
    in_inst = MULT;
    step();
    in_inst = MFLO; flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n = 0;
    while ((in_ready !== 1'b1) && (n < 10)) begin
      step();
      n++;
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL flush_cnt_wait: got %0d cycles want 3", n); end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_delay_slot();
    test_interlock();
    test_illegal();
    test_backpressure();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered, parametrised instruction-decode control stage for the MIPS core pipeline. It sits between the IF/ID instruction register and the EX stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes it into the team's control-word encoding. Compared with the existing combinational decoder it adds:

- a pipeline register,
- downstream backpressure,
- flush,
- a HI/LO multiply/divide interlock counter,
- branch-delay-slot tracking,
- optional COP0 support.

## Interface

Parameters:

- MULDIV_LAT, default 4: cycles HI/LO is busy after a MULT/MULTU/DIV/DIVU is accepted; range 0–15.
- CP0_EN, default 1: when 0, all opcode 010000 instructions decode as bad_inst.

Ports:

- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill the stage contents (exception/redirect).
- in_valid  in  1  instruction present.
- in_ready  out  1  stage accepts this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction PC.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  EX accepts.
- out_inst, out_pc  out  32 each  registered copies of the input.
- alu_op  out  5  ALU operation.
- alu_a_sel  out  1  ALU A-operand select.
- alu_b_sel  out  2  ALU B-operand select.
- reg_write  out  1  register-file write enable.
- reg_dst  out  2  destination select: 00 rd, 01 rt, 10 r31.
- mem_to_reg  out  1  write-back from memory.
- mem_read_en  out  4  load type.
- mem_write  out  4  store byte enables.
- jump  out  2  00 none, 10 jr/jalr, 11 j/jal.
- pc8  out  1  link writes PC+8.
- branch  out  1  conditional branch.
- cp0_write  out  1  COP0 write.
- eret  out  1  ERET.
- trap  out  2  00 none, 10 break, 11 syscall.
- bad_inst  out  1  reserved instruction.
- in_delay_slot  out  1  instruction is in a branch delay slot.

## Operation

Decode encodings are the team's ID control encoding, including:

- ADD 10000, ADDU 10001, SUB 10010, SUBU 10011, AND 10100, OR 10101, SLT 11010, LUI 00111.
- BEQ 00001, BNE 00010.
- Loads: LB 1001, LW 1111.
- Stores: SB 0001, SW 1111.
- R-type: reg_write = (rd != 0).

Handshake and acceptance:

- in_ready = !flush && !interlock && (!out_valid || out_ready).
- A transfer occurs when in_valid && in_ready. On transfer, the register loads the decode of in_inst, plus in_pc and in_inst.

Interlock:

- muldiv_cnt is 4 bits, reset value 0.
- Accepting funct 0110xx (R-type) loads MULDIV_LAT. Otherwise the counter decrements while nonzero, saturating at 0.
- interlock = (muldiv_cnt != 0) && R-type && funct in 0100xx (MFHI/MTHI/MFLO/MTLO) or 0110xx.

Delay slot:

- ds_pending is set on accepting any of: opcode 000001, 000010, 000011, 0001xx, or R-type funct 00100x.
- The next accepted instruction registers in_delay_slot=1, and ds_pending clears at that transfer.
- A branch that is itself in a delay slot sets both: in_delay_slot=1 and ds_pending=1.

Side-effect kill:

- bad_inst = unknown encoding && in_inst != 0. 0x00000000 is SLL r0, so it is a valid NOP.
- If bad_inst or trap != 00, the registered reg_write=0 and mem_write=0.

Bubble:

- If out_valid && out_ready and there is no transfer, then out_valid←0 and all control outputs←0.
- out_inst and out_pc hold their values.

Backpressure:

- While out_valid && !out_ready, all outputs hold stable.

Flush:

- Next cycle: out_valid=0, control outputs zeroed, ds_pending=0.
- muldiv_cnt continues counting down; it is not cleared.
- Flush has priority: there is no transfer in the flush cycle.

Reset:

- Next cycle: out_valid=0, all outputs 0, muldiv_cnt=0, ds_pending=0.
- in_ready=1 after reset deasserts.
- Reset has priority over flush and transfer.

## Timing

- Latency: 1 cycle from transfer to out_valid.
- Throughput: 1 instruction/cycle with out_ready held high.
- in_ready is combinational from flush, out_ready, in_inst and muldiv_cnt. There is no combinational path from in_valid to in_ready.
- Interlock: MULT accepted at cycle t gives muldiv_cnt = MULDIV_LAT at t+1, reaching 0 at t+1+MULDIV_LAT. A dependent HI/LO instruction is first accepted at cycle t+1+MULDIV_LAT.
- MULDIV_LAT=0: no interlock.
- Simultaneous MULT acceptance with a nonzero counter cannot occur, because MULT is itself interlocked.

## Test plan

- Reset, then idle: rst high for 2 cycles → out_valid=0, all control outputs 0, in_ready=1 on the first cycle after rst falls.
- ADDU 0x00221821 streamed with out_ready=1:
  - out_valid=1 one cycle later, alu_op=10001, reg_write=1, reg_dst=00, bad_inst=0.
  - Back-to-back SW 0xAC220004 gives mem_write=1111, reg_write=0 on the next cycle.
- Delay slot: BEQ 0x10220003, then ADDIU 0x24030005, then ADDU 0x00221821:
  - BEQ output: branch=1, alu_op=00001.
  - ADDIU output: in_delay_slot=1.
  - ADDU output: in_delay_slot=0.
- Interlock with MULDIV_LAT=4: MULT 0x00220018 accepted at t, MFLO 0x00001812 presented at t+1 → in_ready=0 for t+1..t+4, MFLO accepted at t+5.
- Illegal instructions:
  - 0xFC000000 → bad_inst=1, reg_write=0, mem_write=0.
  - 0x00000000 → bad_inst=0, reg_write=0.
  - With CP0_EN=0, MFC0 0x40036000 → bad_inst=1.
- Backpressure and flush:
  - out_ready=0 for 3 cycles → outputs stable and in_ready=0.
  - flush asserted together with in_valid → no transfer, out_valid=0 next cycle, ds_pending cleared.
